// File: rtl/wptr_handler.sv
// ---------------------------------------------------------------------------
// wptr_handler
//
// Write-side pointer logic for an asynchronous FIFO. It owns the binary and
// Gray write pointers, brings the read pointer (Gray coded, from the read
// clock domain) across through a two-flop synchronizer, and derives the full,
// almost-full, fill-level and sticky overflow status in the write domain.
//
// Parameters
//   PTR_WIDTH  RAM address width; depth is 2**PTR_WIDTH, pointers carry one
//              extra wrap bit (PTR_WIDTH+1 bits).
//   AF_THRESH  fill level at or above which o_almost_full asserts.
//
// Ports
//   i_Wclk         write-domain clock
//   i_Wrst_n       asynchronous active-low reset
//   i_W_en         write request
//   i_g_rptr       Gray read pointer from the read domain (asynchronous)
//   i_ovf_clr      clears the sticky overflow flag
//   o_b_wptr       registered binary write pointer
//   o_g_wptr       registered Gray write pointer (to the read domain)
//   o_waddr        RAM write address (low bits of o_b_wptr)
//   o_wfull        combinational look-ahead full
//   o_full         registered full
//   o_almost_full  registered almost-full
//   o_wlevel       registered fill level, 0 .. 2**PTR_WIDTH
//   o_overflow     sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module wptr_handler #(
    parameter int PTR_WIDTH = 3,
    parameter int AF_THRESH = 6
) (
    input  logic                 i_Wclk,
    input  logic                 i_Wrst_n,
    input  logic                 i_W_en,
    input  logic [PTR_WIDTH:0]   i_g_rptr,
    input  logic                 i_ovf_clr,
    output logic [PTR_WIDTH:0]   o_b_wptr,
    output logic [PTR_WIDTH:0]   o_g_wptr,
    output logic [PTR_WIDTH-1:0] o_waddr,
    output logic                 o_wfull,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [PTR_WIDTH:0]   o_wlevel,
    output logic                 o_overflow
);

    // The Gray write pointer is exactly one lap ahead of the read pointer
    // when its two MSBs are inverted relative to the read pointer and the
    // rest match. XOR with this mask performs that inversion.
    localparam logic [PTR_WIDTH:0] FULL_MASK = (PTR_WIDTH+1)'(3) << (PTR_WIDTH-1);
    localparam logic [PTR_WIDTH:0] AF_LEVEL  = (PTR_WIDTH+1)'(AF_THRESH);

    logic [PTR_WIDTH:0] r_b_wptr;
    logic [PTR_WIDTH:0] r_g_wptr;
    logic [PTR_WIDTH:0] r_rq1;
    logic [PTR_WIDTH:0] r_rq2;
    logic [PTR_WIDTH:0] r_wlevel;
    logic               r_full;
    logic               r_almost_full;
    logic               r_overflow;

    logic               w_accept;
    logic               w_ovf_set;
    logic [PTR_WIDTH:0] w_b_wptr_next;
    logic [PTR_WIDTH:0] w_g_wptr_next;
    logic [PTR_WIDTH:0] w_rbin;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_wfull;
    logic               w_almost_full_next;
    logic               w_overflow_next;

    // Write acceptance is gated by the registered full flag so the pointer
    // update has no combinational path back through the full compare.
    assign w_accept      = i_W_en & ~r_full;
    assign w_ovf_set     = i_W_en & r_full;
    assign w_b_wptr_next = r_b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
    assign w_g_wptr_next = (w_b_wptr_next >> 1) ^ w_b_wptr_next;

    assign w_wfull = (w_g_wptr_next == (r_rq2 ^ FULL_MASK));

    // Gray-to-binary of the synchronized read pointer: each bit is the XOR
    // of all Gray bits from the MSB down to itself.
    always_comb begin
        w_rbin = '0;
        w_rbin[PTR_WIDTH] = r_rq2[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ r_rq2[i];
        end
    end

    // Modulo subtraction gives the right level across pointer wrap because
    // the pointers carry one extra bit beyond the address.
    assign w_level_next       = w_b_wptr_next - w_rbin;
    assign w_almost_full_next = (w_level_next >= AF_LEVEL);

    // Set has priority over clear so an overflow in the clear cycle is kept.
    assign w_overflow_next = w_ovf_set | (r_overflow & ~i_ovf_clr);

    // Read pointer synchronizer; nothing else samples i_g_rptr.
    always_ff @(posedge i_Wclk or negedge i_Wrst_n) begin
        if (!i_Wrst_n) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= i_g_rptr;
            r_rq2 <= r_rq1;
        end
    end

    always_ff @(posedge i_Wclk or negedge i_Wrst_n) begin
        if (!i_Wrst_n) begin
            r_b_wptr      <= '0;
            r_g_wptr      <= '0;
            r_wlevel      <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_b_wptr      <= w_b_wptr_next;
            r_g_wptr      <= w_g_wptr_next;
            r_wlevel      <= w_level_next;
            r_full        <= w_wfull;
            r_almost_full <= w_almost_full_next;
            r_overflow    <= w_overflow_next;
        end
    end

    assign o_b_wptr      = r_b_wptr;
    assign o_g_wptr      = r_g_wptr;
    assign o_waddr       = r_b_wptr[PTR_WIDTH-1:0];
    assign o_wfull       = w_wfull;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_wlevel      = r_wlevel;
    assign o_overflow    = r_overflow;

endmodule
